// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, multiply/divide FSM
// state encodings and stall-bus constants.
package ex_stage_pkg;

   localparam int DATA_W_DEF      = 16;
   localparam int ADDR_W_DEF      = 4;
   localparam int OP_W_DEF        = 5;
   localparam int STALL_W_DEF     = 6;
   localparam int STALL_EXMEM_BIT = 3;

   localparam logic StallReq   = 1'b1;
   localparam logic NoStallReq = 1'b0;
   localparam logic Stop       = 1'b1;

   typedef enum logic [4:0] {
      ALU_NOP  = 5'd0,
      ALU_ADD  = 5'd1,
      ALU_SUB  = 5'd2,
      ALU_AND  = 5'd3,
      ALU_OR   = 5'd4,
      ALU_XOR  = 5'd5,
      ALU_NOT  = 5'd6,
      ALU_SLL  = 5'd7,
      ALU_SRL  = 5'd8,
      ALU_SRA  = 5'd9,
      ALU_SLT  = 5'd10,
      ALU_SLTU = 5'd11,
      ALU_MOVE = 5'd12,
      ALU_MUL  = 5'd13,
      ALU_DIV  = 5'd14,
      ALU_DIVU = 5'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_DIVU);
   endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply / divide engine (shift-add multiply, restoring divide)
// with IDLE/BUSY/DONE control. Present only when EX_MULDIV_EN is defined.
`ifdef EX_MULDIV_EN
module ex_muldiv
   import ex_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [4:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              stall_hold_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] result_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   md_state_e         state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] acc_q;    // partial product, or running remainder
   logic [DATA_W-1:0] shreg_q;  // multiplier, or dividend shifting into quotient
   logic [DATA_W-1:0] opnd_q;   // multiplicand, or divisor magnitude
   logic              mul_q;
   logic              neg_q;
   logic              dz_q;

   logic              sdiv;
   logic [DATA_W-1:0] a_mag;
   logic [DATA_W-1:0] b_mag;
   logic [DATA_W:0]   rem_shift;
   logic [DATA_W:0]   diff;

   always_comb begin
      sdiv      = (op_i == ALU_DIV);
      a_mag     = (sdiv && a_i[DATA_W-1]) ? -a_i : a_i;
      b_mag     = (sdiv && b_i[DATA_W-1]) ? -b_i : b_i;
      rem_shift = {acc_q, shreg_q[DATA_W-1]};
      diff      = rem_shift - {1'b0, opnd_q};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         shreg_q <= '0;
         opnd_q  <= '0;
         mul_q   <= 1'b0;
         neg_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            MD_IDLE: begin
               if (start_i) begin
                  mul_q   <= (op_i == ALU_MUL);
                  acc_q   <= '0;
                  cnt_q   <= CNT_W'(DATA_W);
                  state_q <= MD_BUSY;
                  if (op_i == ALU_MUL) begin
                     shreg_q <= b_i;
                     opnd_q  <= a_i;
                     neg_q   <= 1'b0;
                     dz_q    <= 1'b0;
                  end else begin
                     shreg_q <= a_mag;
                     opnd_q  <= b_mag;
                     neg_q   <= sdiv && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
                     dz_q    <= (b_i == '0);
                  end
               end
            end
            MD_BUSY: begin
               if (mul_q) begin
                  acc_q   <= acc_q + (shreg_q[0] ? opnd_q : '0);
                  opnd_q  <= opnd_q << 1;
                  shreg_q <= shreg_q >> 1;
               end else if (!diff[DATA_W]) begin
                  acc_q   <= diff[DATA_W-1:0];
                  shreg_q <= {shreg_q[DATA_W-2:0], 1'b1};
               end else begin
                  acc_q   <= rem_shift[DATA_W-1:0];
                  shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
               end
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_q <= MD_DONE;
            end
            MD_DONE: begin
               // id_ex still holds this instruction while EX/MEM is stopped
               if (stall_hold_i != Stop) state_q <= MD_IDLE;
            end
            default: state_q <= MD_IDLE;
         endcase
      end
   end

   assign busy_o   = (state_q == MD_BUSY);
   assign done_o   = (state_q == MD_DONE);
   assign result_o = dz_q  ? '1 :
                     mul_q ? acc_q :
                     neg_q ? -shreg_q : shreg_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU plus output muxing; MUL/DIV/DIVU use the
// iterative ex_muldiv engine when EX_MULDIV_EN is defined, else yield 0.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int OP_W    = OP_W_DEF,
   parameter int STALL_W = STALL_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic [OP_W-1:0]    aluOp_i,
   input  logic [DATA_W-1:0]  operand1_i,
   input  logic [DATA_W-1:0]  operand2_i,
   input  logic               wReg_i,
   input  logic [ADDR_W-1:0]  wRegAddr_i,
   output logic               wReg_o,
   output logic [ADDR_W-1:0]  wRegAddr_o,
   output logic [DATA_W-1:0]  wData_o,
   output logic               stallreq_o
);

   logic [DATA_W-1:0] alu_res;
   logic [3:0]        shamt;
   logic              is_md;
   logic              stall_req;
   logic [DATA_W-1:0] wdata;

   assign is_md = is_muldiv(5'(aluOp_i));
   // shift amount 0 encodes a shift by 8
   assign shamt = (operand2_i[3:0] == 4'd0) ? 4'd8 : operand2_i[3:0];

   always_comb begin
      alu_res = '0;
      case (aluOp_i)
         OP_W'(ALU_ADD):  alu_res = operand1_i + operand2_i;
         OP_W'(ALU_SUB):  alu_res = operand1_i - operand2_i;
         OP_W'(ALU_AND):  alu_res = operand1_i & operand2_i;
         OP_W'(ALU_OR):   alu_res = operand1_i | operand2_i;
         OP_W'(ALU_XOR):  alu_res = operand1_i ^ operand2_i;
         OP_W'(ALU_NOT):  alu_res = ~operand1_i;
         OP_W'(ALU_SLL):  alu_res = operand1_i << shamt;
         OP_W'(ALU_SRL):  alu_res = operand1_i >> shamt;
         OP_W'(ALU_SRA):  alu_res = $signed(operand1_i) >>> shamt;
         OP_W'(ALU_SLT):  alu_res = DATA_W'($signed(operand1_i) < $signed(operand2_i));
         OP_W'(ALU_SLTU): alu_res = DATA_W'(operand1_i < operand2_i);
         OP_W'(ALU_MOVE): alu_res = operand1_i;
         default:         alu_res = '0;
      endcase
   end

`ifdef EX_MULDIV_EN
   logic              md_busy;
   logic              md_done;
   logic [DATA_W-1:0] md_result;
   logic              unused_ok;

   ex_muldiv #(
      .DATA_W(DATA_W)
   ) u_muldiv (
      .clk          (clk),
      .rst          (rst),
      .start_i      (is_md),
      .op_i         (5'(aluOp_i)),
      .a_i          (operand1_i),
      .b_i          (operand2_i),
      .stall_hold_i (stall[STALL_EXMEM_BIT]),
      .busy_o       (md_busy),
      .done_o       (md_done),
      .result_o     (md_result)
   );

   // start cycle (IDLE with a mul/div op) and every BUSY cycle request a stall
   assign stall_req = ((is_md && !md_busy && !md_done) || md_busy) ? StallReq : NoStallReq;
   assign wdata     = md_done ? md_result : (is_md ? '0 : alu_res);
   assign unused_ok = ^(stall & ~(STALL_W'(1) << STALL_EXMEM_BIT));
`else
   logic unused_ok;

   assign stall_req = NoStallReq;
   assign wdata     = is_md ? '0 : alu_res;
   assign unused_ok = ^{clk, stall};
`endif

   assign stallreq_o = rst & stall_req;
   assign wReg_o     = rst & wReg_i & ~stall_req;
   assign wRegAddr_o = rst ? wRegAddr_i : '0;
   assign wData_o    = rst ? wdata : '0;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit pipeline.
- Sits between id_ex and ex_mem: consumes id_ex's aluOp/operands/write-back fields and produces the write-back triple latched by ex_mem.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NOT, SLL, SRL, SRA, SLT, SLTU, MOVE, NOP) are combinational.
- MUL, DIV and DIVU run on an iterative shift/add–subtract engine that stalls the pipeline via stallreq_o.

Parameters:
- DATA_W, 16, operand/result width (RegBus).
- ADDR_W, 4, register address width (RegAddrBus).
- OP_W, 5, aluOp width (AluOpBus).
- STALL_W, 6, stall bus width (StallRegBus).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-low
- stall  in  STALL_W  controller stall vector; bit 3 = EX/MEM hold
- aluOp_i  in  OP_W  operation from id_ex
- operand1_i  in  DATA_W  first operand
- operand2_i  in  DATA_W  second operand / shift amount
- wReg_i  in  1  write-back enable from id_ex
- wRegAddr_i  in  ADDR_W  destination register
- wReg_o  out  1  write-back enable to ex_mem
- wRegAddr_o  out  ADDR_W  destination to ex_mem
- wData_o  out  DATA_W  result to ex_mem
- stallreq_o  out  1  request to hold IF..EX and bubble EX/MEM

Behaviour:
- Reset (rst low, any time, asynchronous):
  - FSM returns to IDLE; iteration counter and accumulators clear.
  - stallreq_o=0, wReg_o=0, wRegAddr_o=0, wData_o=0.
  - Reset mid-operation abandons the operation; no partial result is ever emitted.
- Single-cycle ops:
  - wData_o is combinational from the inputs.
  - wReg_o and wRegAddr_o pass through.
  - Shifts use operand2_i[3:0]; a shift amount of 0 means 8 (THCO convention).
  - SLT is signed, SLTU unsigned; each gives 1 or 0.
  - ADD/SUB wrap modulo 2^DATA_W and have no overflow trap.
- Multi-cycle FSM, states IDLE, BUSY, DONE:
  - IDLE: if aluOp_i is MUL, DIV or DIVU:
    - latch the operands and the operation;
    - counter = DATA_W;
    - stallreq_o=1 combinationally this cycle;
    - next state BUSY.
  - BUSY:
    - one iteration per cycle; counter decrements; stallreq_o=1;
    - inputs are ignored and the latched copies are used;
    - when counter reaches 1, next state is DONE.
  - DONE:
    - stallreq_o=0; wData_o = latched result; wReg_o/wRegAddr_o pass through;
    - if stall[3]=Stop, remain in DONE (id_ex is holding the same instruction, so it must not restart); otherwise next state is IDLE.
  - While IDLE or BUSY with a mul/div op, wReg_o is forced to 0, so a bubble reaches ex_mem.
- Latency: a mul/div spends DATA_W+2 cycles in EX: 1 IDLE start cycle, DATA_W BUSY cycles, 1 DONE cycle. stallreq_o is high for DATA_W+1 of them.
- Back-to-back mul/div: DONE → IDLE sees the next instruction and starts fresh. There is no idle gap beyond the DONE cycle.
- Arithmetic rules:
  - MUL: unsigned shift-add; result = low DATA_W bits of the product (identical for signed operands).
  - DIVU: restoring division; quotient written.
  - DIV: divide magnitudes, then negate the quotient if the operand signs differ.
  - 0x8000/0xFFFF gives 0x8000 (wrap).
  - Divide by zero (DIV and DIVU) gives all-ones (0xFFFF), still takes the full latency, and raises no exception.

Optional Feature:
- Macro EX_MULDIV_EN.
- Defined: MUL/DIV/DIVU behave as above.
- Undefined:
  - the FSM and engine are not instantiated;
  - MUL/DIV/DIVU yield wData_o=0 in one cycle with wReg_o passed through;
  - stallreq_o is tied to 0.

Decomposition:
- defines.v (shared) receives:
  - ALU_MUL, ALU_DIV and ALU_DIVU opcodes alongside the existing ALU_* codes;
  - MD_IDLE, MD_BUSY and MD_DONE state encodings;
  - StallReq/NoStallReq.
- ex_stage holds the combinational ALU and the output muxing.
- Sub-module ex_muldiv holds the FSM, counter, accumulators and sign fix-up.
  - Interface: start, op, a, b, stall_hold, busy, done, result.
  - It is compiled only under EX_MULDIV_EN.

Test Plan:
- Reset: drive rst low mid-BUSY of a DIVU → within the same cycle stallreq_o=0 and all outputs 0; after release, state is IDLE and no result is emitted.
- Single-cycle ops:
  - ADD 0x7FFF+0x0001 → wData_o=0x8000 in the same cycle, wReg_o follows wReg_i.
  - SRA 0x8000 by 0 → 0xFF80.
  - SLT 0xFFFF,0x0001 → 1.
- MUL 0x0123×0x0045 → stallreq_o high 17 cycles, DONE cycle wData_o=0x4E6F, wReg_o=1; preceding cycles wReg_o=0.
- Division cases:
  - DIV 0xFFF9/0x0002 (-7/2) → 0xFFFD.
  - DIVU 0x1234/0 → 0xFFFF after full latency.
  - DIV 0x8000/0xFFFF → 0x8000.
- DONE hold: assert stall[3]=Stop during DONE for 3 cycles → result held, stallreq_o stays 0, no restart. Then back-to-back MUL → second op starts the cycle after DONE.
- Feature off: compile without EX_MULDIV_EN, issue MUL 3×4 → wData_o=0, stallreq_o never rises.
